// File: rtl/ram_lsu.sv
// Load/store initiator for the byte-write / word-read scratch RAM.
// Optional macro LSU_ALIGN_CHECK_EN: reject misaligned word requests with rsp_err.
module ram_lsu #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic             req_size,
  input  logic [DEPTH-1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_data,
  output logic [DEPTH-1:0] ram_addr,
  input  logic [31:0]      ram_rdata
);

  // state | meaning
  // IDLE  | ready for a request
  // WRITE | driving byte writes, one per cycle
  // READ  | driving read addresses, capturing the previous byte
  // DRAIN | capturing the final read byte
  // RESP  | one-cycle response
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

  state_t           state, state_nx;
  logic [2:0]       cnt, cnt_nx, cnt_inc, last;
  logic [1:0]       cnt_m1;
  logic [31:0]      cap, cap_nx;
  logic             is_word;
  logic [DEPTH-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             misalign;

  logic             ready_nx, rsp_valid_nx, rsp_err_nx, ram_we_nx;
  logic [31:0]      rsp_rdata_nx;
  logic [WIDTH-1:0] ram_data_nx;
  logic [DEPTH-1:0] ram_addr_nx;

  logic unused_rdata_hi;
  assign unused_rdata_hi = &{1'b0, ram_rdata[31:8]};

  assign cnt_inc = cnt + 3'd1;
  assign cnt_m1  = cnt[1:0] - 2'd1;
  assign last    = is_word ? 3'd3 : 3'd0;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = req_size && (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ram_we    <= 1'b0;
      ram_data  <= '0;
      ram_addr  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cap       <= cap_nx;
      req_ready <= ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      ram_we    <= ram_we_nx;
      ram_data  <= ram_data_nx;
      ram_addr  <= ram_addr_nx;
    end
  end

  // Request fields are held for the whole transaction so req_* may change while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_word <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_valid) begin
      is_word <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    cap_nx       = cap;
    ready_nx     = 1'b0;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = '0;
    rsp_err_nx   = 1'b0;
    ram_we_nx    = 1'b0;
    ram_data_nx  = ram_data;
    ram_addr_nx  = ram_addr;
    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (req_valid) begin
          ready_nx = 1'b0;
          cnt_nx   = '0;
          cap_nx   = '0;
          if (misalign) begin
            state_nx     = RESP;
            rsp_valid_nx = 1'b1;
            rsp_err_nx   = 1'b1;
          end else if (req_write) begin
            state_nx    = WRITE;
            ram_we_nx   = 1'b1;
            ram_addr_nx = req_addr;
            ram_data_nx = req_wdata[7:0];
          end else begin
            state_nx    = READ;
            ram_addr_nx = req_addr;
          end
        end
      end
      WRITE: begin
        if (cnt == last) begin
          state_nx     = RESP;
          rsp_valid_nx = 1'b1;
        end else begin
          cnt_nx      = cnt_inc;
          ram_we_nx   = 1'b1;
          ram_addr_nx = addr_q + DEPTH'(cnt_inc);
          ram_data_nx = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
        end
      end
      READ: begin
        // RAM output lags the address by one cycle: capture the byte addressed last cycle
        if (cnt != 3'd0) cap_nx[{cnt_m1, 3'b000} +: 8] = ram_rdata[7:0];
        cnt_nx = cnt_inc;
        if (cnt == last) state_nx = DRAIN;
        else             ram_addr_nx = addr_q + DEPTH'(cnt_inc);
      end
      DRAIN: begin
        cap_nx[{cnt_m1, 3'b000} +: 8] = ram_rdata[7:0];
        state_nx     = RESP;
        rsp_valid_nx = 1'b1;
        rsp_rdata_nx = cap_nx;
      end
      RESP: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
    endcase
  end

endmodule
